// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared widths and defaults for the song_reader / voice_allocator / note_player path
package music_pkg;

   localparam int NUM_VOICES_DEF = 3;
   localparam int NOTE_W_DEF     = 6;
   localparam int DUR_W_DEF      = 6;
   localparam int STEAL_CNT_W    = 8;

   // Width of an age rank able to hold 0..n-1; a single voice still gets one bit.
   function automatic int rank_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/voice_allocator_pick.sv
// rtl/voice_allocator_pick.sv - lowest-index free-voice priority encoder
module voice_pick
   import music_pkg::*;
#(
   parameter int NUM_VOICES = NUM_VOICES_DEF
) (
   input  logic [NUM_VOICES-1:0] free_i,
   output logic [NUM_VOICES-1:0] onehot_o,
   output logic                  any_free_o
);

   always_comb begin
      onehot_o = '0;
      // Scan high to low so the lowest free index is the last one written.
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (free_i[i]) begin
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
         end
      end
      any_free_o = |free_i;
   end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - assigns note requests to note_player voices with oldest-voice stealing
module voice_allocator
   import music_pkg::*;
#(
   parameter int NUM_VOICES = NUM_VOICES_DEF,
   parameter int NOTE_W     = NOTE_W_DEF,
   parameter int DUR_W      = DUR_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   steal_enable,
   input  logic                   req_valid,
   input  logic [NOTE_W-1:0]      req_note,
   input  logic [DUR_W-1:0]       req_duration,
   output logic                   req_ready,
   input  logic [NUM_VOICES-1:0]  done_with_note,
   output logic [NUM_VOICES-1:0]  load_new_note,
   output logic [NOTE_W-1:0]      note_to_load,
   output logic [DUR_W-1:0]       duration_to_load,
   output logic [NUM_VOICES-1:0]  voice_busy,
   output logic [STEAL_CNT_W-1:0] steal_count
);

   localparam int RANK_W = rank_width(NUM_VOICES);
   localparam logic [RANK_W-1:0] OLDEST = RANK_W'(NUM_VOICES - 1);

   logic [NUM_VOICES-1:0]  busy_q, busy_d;
   logic [RANK_W-1:0]      rank_q [NUM_VOICES];
   logic [RANK_W-1:0]      rank_d [NUM_VOICES];
   logic [NUM_VOICES-1:0]  load_q, load_d;
   logic [NOTE_W-1:0]      note_q, note_d;
   logic [DUR_W-1:0]       dur_q, dur_d;
   logic [STEAL_CNT_W-1:0] steal_q, steal_d;

   logic [NUM_VOICES-1:0]  free;
   logic [NUM_VOICES-1:0]  pick_oh;
   logic [NUM_VOICES-1:0]  steal_oh;
   logic [NUM_VOICES-1:0]  sel_oh;
   logic [RANK_W-1:0]      sel_rank;
   logic                   any_free;
   logic                   accept;

   voice_pick #(
      .NUM_VOICES(NUM_VOICES)
   ) u_pick (
      .free_i    (free),
      .onehot_o  (pick_oh),
      .any_free_o(any_free)
   );

   // A voice finishing this cycle is already reusable.
   always_comb begin
      free      = ~(busy_q & ~done_with_note);
      req_ready = ~flush & (any_free | steal_enable);
      accept    = req_valid & req_ready;
      steal_oh  = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (rank_q[i] == OLDEST) steal_oh[i] = 1'b1;
      end
      sel_oh   = any_free ? pick_oh : steal_oh;
      sel_rank = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (sel_oh[i]) sel_rank = rank_q[i];
      end
   end

   always_comb begin
      busy_d  = busy_q & ~done_with_note;
      rank_d  = rank_q;
      load_d  = '0;
      note_d  = note_q;
      dur_d   = dur_q;
      steal_d = steal_q;
      if (flush) begin
         busy_d  = '0;
         steal_d = '0;
         for (int i = 0; i < NUM_VOICES; i++) rank_d[i] = RANK_W'(i);
      end else if (accept) begin
         busy_d = busy_d | sel_oh;
         load_d = sel_oh;
         note_d = req_note;
         dur_d  = req_duration;
         if (!any_free && (steal_q != '1)) steal_d = steal_q + 1'b1;
         // Selected voice becomes newest; everything younger than it ages by one.
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (sel_oh[i])                rank_d[i] = '0;
            else if (rank_q[i] < sel_rank) rank_d[i] = rank_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q  <= '0;
         load_q  <= '0;
         note_q  <= '0;
         dur_q   <= '0;
         steal_q <= '0;
         for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= RANK_W'(i);
      end else begin
         busy_q  <= busy_d;
         load_q  <= load_d;
         note_q  <= note_d;
         dur_q   <= dur_d;
         steal_q <= steal_d;
         rank_q  <= rank_d;
      end
   end

   assign load_new_note    = load_q;
   assign note_to_load     = note_q;
   assign duration_to_load = dur_q;
   assign voice_busy       = busy_q;
   assign steal_count      = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator against a recency-list model
module tb_voice_allocator;

   localparam int N  = 3;
   localparam int NW = 6;
   localparam int DW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          steal_enable;
   logic          req_valid;
   logic [NW-1:0] req_note;
   logic [DW-1:0] req_duration;
   logic          req_ready;
   logic [N-1:0]  done_with_note;
   logic [N-1:0]  load_new_note;
   logic [NW-1:0] note_to_load;
   logic [DW-1:0] duration_to_load;
   logic [N-1:0]  voice_busy;
   logic [7:0]    steal_count;

   always #5 clk = ~clk;

   voice_allocator #(
      .NUM_VOICES(N),
      .NOTE_W    (NW),
      .DUR_W     (DW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .steal_enable    (steal_enable),
      .req_valid       (req_valid),
      .req_note        (req_note),
      .req_duration    (req_duration),
      .req_ready       (req_ready),
      .done_with_note  (done_with_note),
      .load_new_note   (load_new_note),
      .note_to_load    (note_to_load),
      .duration_to_load(duration_to_load),
      .voice_busy      (voice_busy),
      .steal_count     (steal_count)
   );

   typedef struct {
      logic [N-1:0]  oh;
      logic [NW-1:0] note;
      logic [DW-1:0] dur;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // Model: busy flags plus a recency list, most recently loaded voice first.
   bit   m_busy[N];
   int   m_rec[$];
   int   m_steal;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic void m_reset();
      m_rec.delete();
      for (int i = 0; i < N; i++) begin
         m_busy[i] = 1'b0;
         m_rec.push_back(i);
      end
      m_steal = 0;
   endfunction

   function automatic logic [N-1:0] busy_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_busy[i];
      return v;
   endfunction

   // Starts just after a rising edge, ends just after the next one.
   task automatic do_cycle(input bit v, input int note, input int dur,
                           input logic [N-1:0] done, input bit st, input bit fl);
      int   sel;
      int   idx;
      bit   exp_ready;
      exp_t e;
      req_valid      = v;
      req_note       = NW'(note);
      req_duration   = DW'(dur);
      done_with_note = done;
      steal_enable   = st;
      flush          = fl;
      #1;
      sel = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_busy[i] || done[i]) sel = i;
      exp_ready = !fl && (sel >= 0 || st);
      check("req_ready", req_ready, exp_ready);
      if (fl) begin
         m_reset();
      end else begin
         for (int i = 0; i < N; i++) if (done[i]) m_busy[i] = 1'b0;
         if (v && exp_ready) begin
            if (sel < 0) begin
               sel = m_rec[m_rec.size() - 1];
               if (m_steal < 255) m_steal++;
            end
            m_busy[sel] = 1'b1;
            idx = 0;
            foreach (m_rec[k]) if (m_rec[k] == sel) idx = k;
            m_rec.delete(idx);
            m_rec.push_front(sel);
            e.oh      = '0;
            e.oh[sel] = 1'b1;
            e.note    = NW'(note);
            e.dur     = DW'(dur);
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      check("voice_busy", voice_busy, busy_vec());
      check("steal_count", steal_count, m_steal);
   endtask

   task automatic idle();
      do_cycle(0, 0, 0, '0, 0, 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset && load_new_note != '0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_strobe: got %b expected none at %0t", load_new_note, $time);
         end else begin
            e = exp_q.pop_front();
            check("load_new_note", load_new_note, e.oh);
            check("note_to_load", note_to_load, e.note);
            check("duration_to_load", duration_to_load, e.dur);
         end
      end
   end

   initial begin
      reset = 1'b0; flush = 1'b0; steal_enable = 1'b0; req_valid = 1'b0;
      req_note = '0; req_duration = '0; done_with_note = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_load", load_new_note, 0);
      check("rst_busy", voice_busy, 0);
      check("rst_note", note_to_load, 0);
      check("rst_dur", duration_to_load, 0);
      check("rst_steal", steal_count, 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;

      do_cycle(1, 10, 4, '0, 0, 0);
      idle();
      do_cycle(0, 0, 0, '0, 0, 1);

      do_cycle(1, 1, 1, '0, 0, 0);
      do_cycle(1, 2, 2, '0, 0, 0);
      do_cycle(1, 3, 3, '0, 0, 0);
      do_cycle(1, 7, 5, '0, 1, 0);
      do_cycle(1, 8, 6, '0, 1, 0);
      idle();

      do_cycle(1, 5, 5, '0, 0, 0);
      do_cycle(1, 6, 6, 3'b010, 0, 0);
      idle();

      do_cycle(1, 9, 9, 3'b010, 1, 1);
      idle();

      do_cycle(1, 1, 1, 3'b100, 0, 0);
      do_cycle(1, 2, 2, '0, 0, 0);
      do_cycle(1, 3, 3, '0, 0, 0);
      for (int i = 0; i < 260; i++) do_cycle(1, i % 64, (i * 7) % 64, '0, 1, 0);
      idle();
      do_cycle(0, 0, 0, '0, 0, 1);

      for (int i = 0; i < 500; i++) begin
         do_cycle($urandom_range(9) < 7, $urandom_range(63), $urandom_range(63),
                  N'($urandom_range(7) & $urandom_range(7)), $urandom_range(1) == 1,
                  $urandom_range(15) == 0);
      end
      idle();

      // Asynchronous reset arriving between acceptance and its strobe edge.
      do_cycle(0, 0, 0, '0, 0, 1);
      req_valid = 1'b1; req_note = 6'd33; req_duration = 6'd12;
      done_with_note = '0; steal_enable = 1'b0; flush = 1'b0;
      #2;
      check("pre_reset_ready", req_ready, 1);
      reset = 1'b0;
      #1;
      check("async_load", load_new_note, 0);
      check("async_busy", voice_busy, 0);
      check("async_note", note_to_load, 0);
      check("async_dur", duration_to_load, 0);
      check("async_steal", steal_count, 0);
      m_reset();
      @(posedge clk);
      #1;
      check("held_load", load_new_note, 0);
      check("held_busy", voice_busy, 0);
      req_valid = 1'b0;
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      do_cycle(1, 20, 21, '0, 0, 0);
      idle();
      idle();

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, number of note_player voices managed.
REQ-002 SHALL have parameter NOTE_W, default 6, note code width.
REQ-003 SHALL have parameter DUR_W, default 6, duration width in beats.
REQ-004 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port flush  input  1  synchronous pulse that releases all voices (song change / reset_player).
REQ-007 SHALL have port steal_enable  input  1  permits reallocation of the oldest busy voice when none is free.
REQ-008 SHALL have port req_valid  input  1  song-side note request valid.
REQ-009 SHALL have port req_note  input  NOTE_W  requested note.
REQ-010 SHALL have port req_duration  input  DUR_W  requested duration.
REQ-011 SHALL have port req_ready  output  1  allocator can accept a request this cycle.
REQ-012 SHALL have port done_with_note  input  NUM_VOICES  per-voice one-cycle completion pulses from note players.
REQ-013 SHALL have port load_new_note  output  NUM_VOICES  one-hot, one-cycle load strobe to the selected voice.
REQ-014 SHALL have port note_to_load  output  NOTE_W  registered note, valid while load_new_note != 0.
REQ-015 SHALL have port duration_to_load  output  DUR_W  registered duration, valid with note_to_load.
REQ-016 SHALL have port voice_busy  output  NUM_VOICES  per-voice busy flags.
REQ-017 SHALL have port steal_count  output  8  saturating count of steals since reset/flush.

Function
REQ-018 Acceptance SHALL occur on any cycle with req_valid & req_ready; request fields SHALL be sampled that cycle.
REQ-019 req_ready SHALL be combinational: ~flush & (any bit of (voice_busy & ~done_with_note) clear | steal_enable).
REQ-020 A voice whose done_with_note is high SHALL count as free in the same cycle.
REQ-021 Among free voices, the lowest index SHALL be selected.
REQ-022 With no free voice and steal_enable=1, the voice with oldest age rank (NUM_VOICES-1) SHALL be selected and steal_count incremented, saturating at 255.
REQ-023 Latency: load_new_note SHALL pulse exactly one cycle after acceptance, one-hot on the selected voice, with note_to_load/duration_to_load registered the same edge.
REQ-024 load_new_note SHALL be all-zero in cycles following non-accepting cycles; note_to_load/duration_to_load SHALL hold last values.
REQ-025 Busy update per edge: busy_next = (busy & ~done_with_note) | onehot(selected on acceptance).
REQ-026 Age ranks SHALL form a permutation of 0..NUM_VOICES-1; on acceptance the selected voice becomes rank 0 and every voice with rank below its old rank increments by 1; others unchanged.
REQ-027 flush SHALL clear voice_busy, steal_count, pending load strobe, restore ranks to rank[i]=i, and block acceptance that cycle; done_with_note during flush SHALL be ignored.
REQ-028 done_with_note on a non-busy voice SHALL have no effect.

Reset
REQ-029 While reset=0: voice_busy=0, load_new_note=0, note_to_load=0, duration_to_load=0, steal_count=0, rank[i]=i.
REQ-030 Reset SHALL take effect asynchronously mid-operation, discarding any accepted but not yet strobed request; release SHALL be synchronous to clk.

Structure
REQ-031 NOTE_W, DUR_W, NUM_VOICES defaults SHALL reside in shared package music_pkg, reused by song_reader and note_player.
REQ-032 Free-voice lowest-index selection SHALL be a sub-module voice_pick (NUM_VOICES-wide priority encoder, outputs one-hot and any_free).
REQ-033 Block SHALL contain no multi-cycle FSM beyond the one-stage load register; all state is busy, ranks, load register, steal_count.

Verification
REQ-034 Reset, then req note=10 dur=4 -> next cycle load_new_note=001, note_to_load=10, duration_to_load=4, voice_busy=001.
REQ-035 Three back-to-back requests (notes 1,2,3) -> strobes 001,010,100 on successive cycles; voice_busy=111; ranks v2=0,v1=1,v0=2.
REQ-036 All busy, steal_enable=0, req_valid=1 -> req_ready=0; assert done_with_note=010 -> same cycle req_ready=1, next cycle load_new_note=010, voice_busy=111.
REQ-037 All busy, steal_enable=1, request note=7 -> voice 0 (oldest) strobed, steal_count=1; second request -> voice 1 strobed, steal_count=2.
REQ-038 flush with voice_busy=111 and req_valid=1 -> req_ready=0, next cycle voice_busy=000, steal_count=0, no strobe.
REQ-039 reset driven low one cycle after acceptance -> load_new_note stays 000 and all outputs at reset values immediately.
